conv_accum: RTL and testbench

CONV_ACCUM -- requirements
Module: conv_accum

---
 rtl/conv_pkg.sv | 36 +++
 rtl/functions_pkg.sv | 13 +
 rtl/conv_dot.sv | 81 ++++++++
 rtl/conv_accum.sv | 114 +++++++++++
 tb/tb_conv_accum.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Sizing helpers and output rounding/saturation shared by conv_accum and conv_dot.
package conv_pkg;
  import functions_pkg::*;

  function automatic int sum_stage_num(input int kern_size);
    return clog2(kern_size);
  endfunction

  // One guard bit on top of the worst-case growth covers the bias term.
  function automatic int acc_width(input int din_w, input int kern_w,
                                   input int kern_size, input int ch_num);
    return din_w + kern_w + clog2(kern_size * ch_num) + 1;
  endfunction

  function automatic int tree_nodes(input int kern_size, input int level);
    return (kern_size + (1 << level) - 1) >> level;
  endfunction

  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int shift);
    if (shift <= 0) return v;
    return (v + (64'sd1 <<< (shift - 1))) >>> shift;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/functions_pkg.sv
// Shared elaboration-time helpers used across the datapath blocks.
package functions_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_dot.sv
// Full-precision dot product of one beat: registered multiplies feeding a
// registered pairwise adder tree, with a sideband tag carried in lockstep.
module conv_dot
  import conv_pkg::*;
#(
  parameter int KERN_WIDTH = 16,
  parameter int DIN_WIDTH  = 8,
  parameter int KERN_SIZE  = 3,
  parameter int TAG_W      = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                en,
  input  logic                                in_vld,
  input  logic [KERN_SIZE-1:0][DIN_WIDTH-1:0]  din,
  input  logic [KERN_SIZE-1:0][KERN_WIDTH-1:0] kernel,
  input  logic [TAG_W-1:0]                     tag,
  output logic                                out_vld,
  output logic signed [DIN_WIDTH+KERN_WIDTH+sum_stage_num(KERN_SIZE)-1:0] sum,
  output logic [TAG_W-1:0]                     out_tag
);

  localparam int STAGES = sum_stage_num(KERN_SIZE);
  localparam int PROD_W = DIN_WIDTH + KERN_WIDTH;
  localparam int SUM_W  = PROD_W + STAGES;

  logic signed [PROD_W-1:0] prod [KERN_SIZE];
  logic [STAGES:0]          vld_p;
  logic [TAG_W-1:0]         tag_p [STAGES+1];

  always_comb begin
    for (int i = 0; i < KERN_SIZE; i++) begin
      prod[i] = PROD_W'($signed(din[i])) * PROD_W'($signed(kernel[i]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
    end else if (en) begin
      vld_p[0] <= in_vld;
      for (int i = 1; i <= STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tag_p[0] <= tag;
      for (int i = 1; i <= STAGES; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // Level 0 holds the products; each later level halves the operand count.
  for (genvar l = 0; l <= STAGES; l++) begin : g_lvl
    localparam int CNT = tree_nodes(KERN_SIZE, l);
    logic signed [SUM_W-1:0] node [CNT];
    if (l == 0) begin : g_mult
      always_ff @(posedge clk) begin
        if (en) for (int i = 0; i < CNT; i++) node[i] <= SUM_W'(prod[i]);
      end
    end else begin : g_add
      localparam int PREV = tree_nodes(KERN_SIZE, l - 1);
      always_ff @(posedge clk) begin
        if (en) begin
          for (int i = 0; i < CNT; i++) begin
            if (2 * i + 1 < PREV)
              node[i] <= g_lvl[l-1].node[2*i] +
                         g_lvl[l-1].node[(2*i+1 < PREV) ? 2*i+1 : 0];
            else
              node[i] <= g_lvl[l-1].node[2*i];
          end
        end
      end
    end
  end

  assign sum     = g_lvl[STAGES].node[0];
  assign out_vld = vld_p[STAGES];
  assign out_tag = tag_p[STAGES];

endmodule

// File: rtl/conv_accum.sv
// Multi-channel convolution accumulator: dot product per beat, per-group
// accumulation with bias, then round, saturate and optional relu.
module conv_accum
  import conv_pkg::*, functions_pkg::*;
#(
  parameter int KERN_WIDTH = 16,
  parameter int DIN_WIDTH  = 8,
  parameter int DOUT_WIDTH = 8,
  parameter int KERN_SIZE  = 3,
  parameter int CH_NUM     = 4,
  parameter int OUT_SHIFT  = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                din_vld,
  output logic                                din_rdy,
  input  logic [KERN_SIZE-1:0][DIN_WIDTH-1:0]  din,
  input  logic [KERN_SIZE-1:0][KERN_WIDTH-1:0] kernel,
  input  logic signed [KERN_WIDTH-1:0]         bias,
  input  logic                                relu_en,
  output logic                                dout_vld,
  input  logic                                dout_rdy,
  output logic signed [DOUT_WIDTH-1:0]         dout
);

  localparam int SUM_STAGE_NUM = sum_stage_num(KERN_SIZE);
  localparam int ACC_WIDTH     = acc_width(DIN_WIDTH, KERN_WIDTH, KERN_SIZE, CH_NUM);
  localparam int SUM_W         = DIN_WIDTH + KERN_WIDTH + SUM_STAGE_NUM;
  localparam int CNT_W         = (CH_NUM > 1) ? clog2(CH_NUM) : 1;
  localparam int TAG_W         = KERN_WIDTH + 3;

  logic                         stall;
  logic                         en;
  logic                         accept;
  logic [CNT_W-1:0]             ch;
  logic                         first;
  logic                         last;
  logic                         dot_vld;
  logic signed [SUM_W-1:0]      dot_sum;
  logic [TAG_W-1:0]             dot_tag;
  logic signed [ACC_WIDTH-1:0]  acc_p0;
  logic                         vld_p0;
  logic                         relu_p0;
  logic signed [ACC_WIDTH:0]    rnd_p1;
  logic                         vld_p1;
  logic                         relu_p1;
  logic signed [DOUT_WIDTH-1:0] res;

  assign stall   = dout_vld & ~dout_rdy;
  assign en      = ~stall;
  assign din_rdy = en;
  assign accept  = din_vld & din_rdy;
  assign first   = (ch == '0);
  assign last    = (ch == CNT_W'(CH_NUM - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    ch <= '0;
    else if (accept) ch <= last ? '0 : ch + CNT_W'(1);
  end

  conv_dot #(
    .KERN_WIDTH (KERN_WIDTH),
    .DIN_WIDTH  (DIN_WIDTH),
    .KERN_SIZE  (KERN_SIZE),
    .TAG_W      (TAG_W)
  ) u_dot (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .in_vld  (accept),
    .din     (din),
    .kernel  (kernel),
    .tag     ({first, last, relu_en, bias}),
    .out_vld (dot_vld),
    .sum     (dot_sum),
    .out_tag (dot_tag)
  );

  always_comb begin
    res = DOUT_WIDTH'(saturate(64'(rnd_p1), DOUT_WIDTH));
    if (relu_p1 && res < 0) res = '0;
  end

  // p0: accumulate; p1: round and shift; output register: saturate and relu.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_p0   <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      dout_vld <= 1'b0;
      dout     <= '0;
    end else if (en) begin
      if (dot_vld) begin
        if (dot_tag[TAG_W-1])
          acc_p0 <= ACC_WIDTH'($signed(dot_tag[KERN_WIDTH-1:0])) + ACC_WIDTH'(dot_sum);
        else
          acc_p0 <= acc_p0 + ACC_WIDTH'(dot_sum);
      end
      vld_p0   <= dot_vld & dot_tag[TAG_W-2];
      vld_p1   <= vld_p0;
      dout_vld <= vld_p1;
      if (vld_p1) dout <= res;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (dot_vld) relu_p0 <= dot_tag[TAG_W-3];
      rnd_p1  <= (ACC_WIDTH+1)'(round_shift(64'(acc_p0), OUT_SHIFT));
      relu_p1 <= relu_p0;
    end
  end

endmodule

// File: tb/tb_conv_accum.sv
// Directed and randomized checks of conv_accum (KERN_SIZE=3, CH_NUM=2, 8-bit data, OUT_SHIFT=4).
module tb_conv_accum;

  localparam int KS = 3;
  localparam int CH = 2;
  localparam int SH = 4;

  logic                clk;
  logic                reset_n;
  logic                din_vld;
  logic                din_rdy;
  logic [KS-1:0][7:0]  din;
  logic [KS-1:0][7:0]  kernel;
  logic signed [7:0]   bias;
  logic                relu_en;
  logic                dout_vld;
  logic                dout_rdy;
  logic signed [7:0]   dout;

  conv_accum #(
    .KERN_WIDTH (8),
    .DIN_WIDTH  (8),
    .DOUT_WIDTH (8),
    .KERN_SIZE  (KS),
    .CH_NUM     (CH),
    .OUT_SHIFT  (SH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .din      (din),
    .kernel   (kernel),
    .bias     (bias),
    .relu_en  (relu_en),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              vectors = 0;
  int              miscompares = 0;
  longint          exp_q [$];
  int              m_ch = 0;
  longint          m_acc = 0;
  int              beats = 0;
  bit              prev_stalled = 1'b0;
  logic signed [7:0] prev_dout = '0;
  bit              last_hs = 1'b0;
  logic signed [7:0] last_dout = '0;
  bit              s_vld = 1'b0;

  task automatic check(input string tag, input longint obs, input longint req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  function automatic longint ref_out(input longint acc, input bit relu);
    longint r;
    r = (acc + (64'sd1 <<< (SH - 1))) >>> SH;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    longint dp;
    #1;
    s_vld = dout_vld;
    check("din_rdy", longint'(din_rdy), longint'(!(dout_vld && !dout_rdy)));
    if (prev_stalled) begin
      check("stall_dout_hold", longint'(dout), longint'(prev_dout));
      check("stall_vld_hold", longint'(dout_vld), 1);
    end
    last_hs = dout_vld && dout_rdy;
    if (last_hs) begin
      last_dout = dout;
      if (exp_q.size() == 0) check("spurious_result", longint'(dout), 1000);
      else                   check("result", longint'(dout), exp_q.pop_front());
    end
    prev_stalled = dout_vld && !dout_rdy;
    prev_dout    = dout;
    if (din_vld && din_rdy) begin
      dp = 0;
      for (int i = 0; i < KS; i++)
        dp += longint'($signed(din[i])) * longint'($signed(kernel[i]));
      if (m_ch == 0) m_acc = longint'(bias) + dp;
      else           m_acc = m_acc + dp;
      if (m_ch == CH - 1) begin
        exp_q.push_back(ref_out(m_acc, relu_en));
        m_ch = 0;
      end else begin
        m_ch++;
      end
      beats++;
    end
    @(negedge clk);
  endtask

  task automatic set_uniform(input int d, input int k);
    for (int i = 0; i < KS; i++) begin
      din[i]    = 8'(d);
      kernel[i] = 8'(k);
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < KS; i++) begin
      din[i]    = 8'($urandom);
      kernel[i] = 8'($urandom);
    end
    bias    = 8'($urandom);
    relu_en = 1'($urandom);
  endtask

  task automatic directed(input string tag, input int d, input int k, input int b,
                          input bit relu, input longint expv);
    int     lat;
    longint val;
    lat = -1;
    val = -999;
    set_uniform(d, k);
    bias     = 8'(b);
    relu_en  = relu;
    dout_rdy = 1'b1;
    din_vld  = 1'b1;
    tick();
    tick();
    din_vld = 1'b0;
    for (int n = 0; n < 20 && lat < 0; n++) begin
      tick();
      if (last_hs) begin
        lat = n;
        val = longint'(last_dout);
      end
    end
    tick();
    check({tag, "_latency"}, lat, 5);
    check({tag, "_value"}, val, expv);
    check({tag, "_vld_drop"}, longint'(s_vld), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_dout_vld", longint'(dout_vld), 0);
    check("rst_dout", longint'(dout), 0);
    check("rst_din_rdy", longint'(din_rdy), 1);
    @(negedge clk);
    @(negedge clk);
    reset_n      = 1'b1;
    m_ch         = 0;
    m_acc        = 0;
    prev_stalled = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) tick();
    tick();
    tick();
    check({tag, "_drained"}, longint'(exp_q.size()), 0);
  endtask

  initial begin
    int stalls;
    int extra;
    int start;
    reset_n  = 1'b0;
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    relu_en  = 1'b0;
    bias     = '0;
    set_uniform(0, 0);
    @(negedge clk);
    do_reset();
    @(negedge clk);

    directed("basic16", 16, 16, 0, 1'b0, 96);
    directed("sat_pos", 127, 127, 0, 1'b0, 127);
    directed("sat_neg", -128, 127, 0, 1'b0, -128);
    directed("rnd_pos", 1, 4, 0, 1'b0, 2);
    directed("rnd_neg", 1, -4, 0, 1'b0, -1);
    directed("relu", 1, -4, 0, 1'b1, 0);
    directed("bias8", 0, 0, 8, 1'b0, 1);

    // Backpressure during continuous input.
    stalls = 0;
    din_vld = 1'b1;
    for (int c = 0; c < 40; c++) begin
      set_random();
      dout_rdy = !(c >= 12 && c < 22);
      tick();
      if (prev_stalled) stalls++;
    end
    check("bp_stall_seen", longint'(stalls >= 5), 1);
    drain("bp");

    // Reset in the middle of a group.
    set_uniform(5, 7);
    bias    = 8'sd3;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    do_reset();
    @(negedge clk);
    directed("midrst", 16, 16, 0, 1'b0, 96);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (last_hs) extra++;
    end
    check("midrst_single", extra, 0);

    // Random valid/ready traffic.
    start = beats;
    for (int c = 0; c < 60000 && (beats - start) < 10000; c++) begin
      set_random();
      din_vld  = ($urandom_range(0, 3) != 0);
      dout_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("rand_beats", longint'((beats - start) >= 10000), 1);
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
